// File: rtl/rev32_share_ctrl.sv
// Two-requester front end for a shared 16-bit bit-reverser.
// Each accepted 32-bit operand is reversed in two half-word passes and returned on a valid/ready response.
module rev32_share_ctrl #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_data,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_data,
  output logic [15:0] o_rev_in,
  input  logic [15:0] i_rev_out,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_id,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_op;
  logic        r_id;
  logic        r_prio;
  logic [15:0] r_res_hi;
  logic [31:0] r_rsp_data;
  logic        r_rsp_valid;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;

  // The priority pointer only breaks ties; a lone requester always wins.
  always_comb begin
    w_grant0 = i_req0_valid & (~i_req1_valid | ~r_prio);
    w_grant1 = i_req1_valid & (~i_req0_valid |  r_prio);
  end

  assign w_accept = (r_state == S_IDLE) & (w_grant0 | w_grant1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_LO;
      S_LO:   w_state_next = S_HI;
      S_HI:   w_state_next = S_RESP;
      S_RESP: if (i_rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_rev_in     = 16'h0000;
    case (r_state)
      S_IDLE: begin
        o_req0_ready = w_grant0;
        o_req1_ready = w_grant1;
      end
      S_LO:    o_rev_in = r_op[15:0];
      S_HI:    o_rev_in = r_op[31:16];
      default: o_rev_in = 16'h0000;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);

  // The low-half result is staged so the visible response only changes when HI completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op        <= 32'h0000_0000;
      r_id        <= 1'b0;
      r_prio      <= RR_INIT;
      r_res_hi    <= 16'h0000;
      r_rsp_data  <= 32'h0000_0000;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= w_grant0 ? i_req0_data : i_req1_data;
        r_id <= w_grant1;
      end
      if (r_state == S_LO) r_res_hi <= i_rev_out;
      if (r_state == S_HI) r_rsp_data <= {r_res_hi, i_rev_out};
      r_rsp_valid <= (w_state_next == S_RESP);
      if ((r_state == S_RESP) && i_rsp_ready) r_prio <= ~r_id;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_id    = r_id;

endmodule
